// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bundle between the ALU/load sources, the arbiter and the register file.
// Carries both request channels, the stall, the register file write port and status.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              stall;
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              rf_write_en;
  logic              rf_enable;
  logic [ADDR_W-1:0] rf_addr_wr;
  logic [DATA_W-1:0] rf_data_wr;
  logic [7:0]        pending;
  logic [7:0]        wb_count;

  modport master (
    output stall,
    output alu_valid, alu_addr, alu_data,
    output ld_valid, ld_addr, ld_data,
    input  alu_ready, ld_ready,
    input  rf_write_en, rf_enable,
    input  rf_addr_wr, rf_data_wr,
    input  pending, wb_count
  );

  modport slave (
    input  stall,
    input  alu_valid, alu_addr, alu_data,
    input  ld_valid, ld_addr, ld_data,
    output alu_ready, ld_ready,
    output rf_write_en, rf_enable,
    output rf_addr_wr, rf_data_wr,
    output pending, wb_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter feeding the register file write port via a 1-entry stage.
// Define WB_RR_EN for round-robin priority; otherwise the ALU wins every conflict.
module regfile_wb_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input logic             clk,
  input logic             rst,
  regfile_wb_arbiter_if.slave bus
);

  logic              stage_valid;
  logic [ADDR_W-1:0] stage_addr;
  logic [DATA_W-1:0] stage_data;
  logic [7:0]        cnt;

  logic              space;
  logic              grant_alu;
  logic              grant_ld;
  logic              accept;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // Reset blocks grants so nothing is accepted on the reset edge
  assign space = !rst && (!stage_valid || !bus.stall);

`ifdef WB_RR_EN
  logic last_ld;

  assign grant_alu = space && bus.alu_valid &&
                     (!bus.ld_valid || last_ld);
  assign grant_ld  = space && bus.ld_valid &&
                     !(bus.alu_valid && last_ld);

  always_ff @(posedge clk) begin
    if (rst)
      last_ld <= 1'b1;
    else if (accept)
      last_ld <= grant_ld;
  end
`else
  assign grant_alu = space && bus.alu_valid;
  assign grant_ld  = space && bus.ld_valid && !bus.alu_valid;
`endif

  assign accept   = grant_alu || grant_ld;
  assign win_addr = grant_ld ? bus.ld_addr : bus.alu_addr;
  assign win_data = grant_ld ? bus.ld_data : bus.alu_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_addr  <= '0;
      stage_data  <= '0;
    end else if (accept) begin
      stage_valid <= (win_addr != '0);
      stage_addr  <= win_addr;
      stage_data  <= win_data;
    end else if (!bus.stall) begin
      stage_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (stage_valid && !bus.stall && cnt != 8'hFF)
      cnt <= cnt + 8'd1;
  end

  // Outputs are masked during reset so the reset edge never writes the file
  assign bus.alu_ready   = grant_alu;
  assign bus.ld_ready    = grant_ld;
  assign bus.rf_write_en = stage_valid && !rst;
  assign bus.rf_enable   = !bus.stall;
  assign bus.rf_addr_wr  = rst ? '0 : stage_addr;
  assign bus.rf_data_wr  = rst ? '0 : stage_data;
  assign bus.pending     = (stage_valid && !rst) ?
                           (8'd1 << stage_addr) : 8'd0;
  assign bus.wb_count    = rst ? 8'd0 : cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: driver pushes expected handshake/commit data, monitor pops and compares.
// Reference model tracks occupancy, priority and commit count from the behavioural rules.
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic ar;
    logic lr;
    logic we;
    int   cnt;
  } exp_t;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
  } wr_t;

  exp_t rq[$];
  wr_t  wq[$];

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_busy    = 0;
  bit m_last_ld = 1;
  int m_cnt     = 0;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d t=%0t",
               name, act, req, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit st,
                       input bit av, input int aa, input int ad,
                       input bit lv, input int la, input int ldd);
    exp_t e;
    wr_t  w;
    bit   sp, ga, gl;
    @(negedge clk);
    #1;
    rst           = r;
    bus.stall     = st;
    bus.alu_valid = av;
    bus.alu_addr  = 3'(aa);
    bus.alu_data  = 8'(ad);
    bus.ld_valid  = lv;
    bus.ld_addr   = 3'(la);
    bus.ld_data   = 8'(ldd);
    sp = !r && (!m_busy || !st);
    ga = 0;
    gl = 0;
    if (sp) begin
      if (av && lv) begin
`ifdef WB_RR_EN
        if (m_last_ld) ga = 1; else gl = 1;
`else
        ga = 1;
`endif
      end else begin
        ga = av;
        gl = lv;
      end
    end
    e.ar  = ga;
    e.lr  = gl;
    e.we  = r ? 1'b0 : m_busy;
    e.cnt = r ? 0 : m_cnt;
    rq.push_back(e);
    if (r) begin
      m_busy    = 0;
      m_cnt     = 0;
      m_last_ld = 1;
      wq.delete();
    end else begin
      if (m_busy && !st && m_cnt < 255) m_cnt++;
      if (ga || gl) begin
        w.a = gl ? 3'(la) : 3'(aa);
        w.d = gl ? 8'(ldd) : 8'(ad);
        m_busy    = (w.a != 0);
        m_last_ld = gl;
        if (w.a != 0) wq.push_back(w);
      end else if (!st) begin
        m_busy = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor: samples just before each rising edge
  initial begin
    exp_t e;
    wr_t  w;
    forever begin
      @(negedge clk);
      #4;
      if (rq.size() > 0) begin
        e = rq.pop_front();
        chk("alu_ready", int'(bus.alu_ready), int'(e.ar));
        chk("ld_ready", int'(bus.ld_ready), int'(e.lr));
        chk("rf_write_en", int'(bus.rf_write_en), int'(e.we));
        chk("wb_count", int'(bus.wb_count), e.cnt);
        chk("rf_enable", int'(bus.rf_enable), int'(!bus.stall));
        if (e.we) begin
          if (wq.size() == 0) begin
            chk("write_queue", wq.size(), 1);
          end else begin
            w = wq[0];
            chk("rf_addr_wr", int'(bus.rf_addr_wr), int'(w.a));
            chk("rf_data_wr", int'(bus.rf_data_wr), int'(w.d));
            chk("pending", int'(bus.pending), 1 << w.a);
            if (bus.rf_enable) void'(wq.pop_front());
          end
        end else begin
          chk("pending_idle", int'(bus.pending), 0);
        end
      end
    end
  end

  initial begin
    bus.stall     = 0;
    bus.alu_valid = 0;
    bus.alu_addr  = 0;
    bus.alu_data  = 0;
    bus.ld_valid  = 0;
    bus.ld_addr   = 0;
    bus.ld_data   = 0;

    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 3, 8'h5A, 1, 2, 8'h22);
    idle(1);

    // single write
    cycle(0, 0, 1, 3, 8'h5A, 0, 0, 0);
    idle(2);

    // R0 drop on load path
    cycle(0, 0, 0, 0, 0, 1, 0, 8'hFF);
    idle(2);

    // conflict, 4 cycles
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      cycle(0, 0, 1, 1, 8'h11, 1, 2, 8'h22);
    idle(2);

    // stall with queued request
    cycle(0, 0, 1, 4, 8'h33, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      cycle(0, 1, 0, 0, 0, 1, 5, 8'h44);
    cycle(0, 0, 0, 0, 0, 1, 5, 8'h44);
    idle(2);

    // absorb into empty stage during stall
    cycle(0, 1, 1, 6, 8'h66, 0, 0, 0);
    cycle(0, 1, 1, 2, 8'h67, 0, 0, 0);
    idle(2);

    // reset mid-transfer
    cycle(0, 0, 1, 5, 8'h55, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // saturation
    for (int i = 0; i < 300; i++)
      cycle(0, 0, 1, 7, $urandom_range(0, 255), 0, 0, 0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 99) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 7), $urandom_range(0, 255),
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 7), $urandom_range(0, 255));
    idle(4);

    @(negedge clk);
    #6;
    chk("writes_left", wq.size(), 0);
    chk("responses_left", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

- Shares the register file's single write port between two writeback sources: the ALU result path and the load path.
- Arbitrates between them using a valid/ready handshake per source.
- Registers the winning write in a one-entry output stage, which drives the register file's write_en/enable/addr_wr/data_wr inputs.
- Exports the in-flight destination as a mask for decode-stage hazard detection.

## Interface
Parameters:
- DATA_W, 8, writeback data width (matches register file entry width)
- ADDR_W, 3, register address width (8 architectural registers, R0 hardwired zero)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  global pipeline stall; freezes output stage and grants
- alu_valid  in  1  ALU write request
- alu_ready  out  1  ALU request accepted this cycle when alu_valid && alu_ready
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- ld_valid  in  1  load write request
- ld_ready  out  1  load request accepted when ld_valid && ld_ready
- ld_addr  in  ADDR_W  load destination register
- ld_data  in  DATA_W  load data
- rf_write_en  out  1  to register file write_en
- rf_enable  out  1  to register file enable
- rf_addr_wr  out  ADDR_W  to register file addr_wr
- rf_data_wr  out  DATA_W  to register file data_wr
- pending  out  8  one-hot mask of the destination held in the output stage; bit 0 always 0
- wb_count  out  8  count of committed writes, saturating

## Operation
- Output stage holds: stage_valid, stage_addr, stage_data.
- Outputs driven from the stage:
  - rf_write_en = stage_valid
  - rf_enable = !stall
  - rf_addr_wr = stage_addr
  - rf_data_wr = stage_data
- The stage can accept a new entry when space = !stage_valid || !stall.
- Grant:
  - The grant is combinational from alu_valid, ld_valid, space and the priority state.
  - At most one of alu_ready and ld_ready is high in any cycle.
  - Both ready signals are 0 when space = 0.
  - A lone valid requester is granted whenever space = 1.
- Acceptance:
  - The stage loads {valid, addr, data} from the granted source.
  - Destination R0: the request is accepted (ready high) but stage_valid loads 0. The write is dropped, not counted, and pending stays 0.
- Draining:
  - With stall = 0 and no acceptance, stage_valid clears at the next edge.
  - With stall = 1, the stage holds its contents unchanged.
- wb_count increments by 1 at each edge where stage_valid && !stall; it holds at 255.
- pending[stage_addr] = stage_valid; all other bits are 0.
- Reset:
  - All outputs are 0 except rf_enable, which follows !stall.
  - stage_valid = 0, wb_count = 0, priority pointer = "load last granted".
  - Reset mid-transfer discards the stage contents. No write reaches the register file on the reset edge.

## Timing
- Request accepted at edge N.
- rf_write_en is high during cycle N..N+1.
- The register file updates at edge N+1, if stall = 0 in that cycle.
- Back-to-back acceptance is allowed: each source sustains one write per cycle with no bubble when stall = 0.
- Stall:
  - stall = 1 blocks new grants unless the stage is empty; one entry may be absorbed into an empty stage during a stall.
  - When stall drops, the held write commits on the next edge, and a new grant in the same cycle loads the stage.
- Both sources target the same register in consecutive cycles: the writes commit in grant order, and the later write wins.
- Readback of a just-written register is visible through the register file's asynchronous read after edge N+1. No forwarding is done here.

## Configuration
- WB_RR_EN defined:
  - Round-robin priority. When both sources are valid and space = 1, grant goes to the source not granted last.
  - The pointer updates only on an actual acceptance, including R0 acceptances.
  - After reset the ALU wins the first conflict.
- WB_RR_EN undefined:
  - Fixed priority, with the ALU always winning a conflict.
  - The load path is granted only when alu_valid = 0.
  - The pointer register is absent.

## Test plan
- Single write:
  - Stimulus: alu_valid with addr 3, data 0x5A; stall = 0.
  - Response: alu_ready = 1; next cycle rf_write_en = 1, rf_addr_wr = 3, rf_data_wr = 0x5A, pending = 0x08; wb_count = 1 after commit.
- R0 drop:
  - Stimulus: ld_valid with addr 0, data 0xFF.
  - Response: ld_ready = 1; rf_write_en stays 0, pending = 0, wb_count unchanged.
- Conflict with WB_RR_EN:
  - Stimulus: both sources valid for 4 cycles (ALU addr 1 / 0x11, load addr 2 / 0x22).
  - Response: grants alternate ALU, load, ALU, load; rf_addr_wr sequence 1, 2, 1, 2.
- Conflict without WB_RR_EN:
  - Stimulus: the same as the previous scenario.
  - Response: ALU is granted for all 4 cycles and ld_ready stays 0.
- Stall:
  - Stimulus: write accepted (addr 4, data 0x33), then stall = 1 for 3 cycles.
  - Response: the stage holds and both ready signals are 0. When stall drops, wb_count increments once and the queued request is granted in the same cycle.
- Reset and saturation:
  - Stimulus: assert rst while stage_valid = 1.
  - Response: rf_write_en = 0 and wb_count = 0 next cycle.
  - Stimulus: 300 consecutive ALU writes to addr 7.
  - Response: wb_count = 255.
